om_bank_ctrl: RTL and testbench
===============================

// Module: om_bank_ctrl
// PURPOSE
// - Parametrised output-memory controller: NUM_CH single-port result banks
//   (one per window scale). Each bank is shared by the ANN, post-processing
//   (PostP), Set and built-in Clear writers.
// - Adds three things: a hardware Clear sweep, per-channel completion
//   tracking, and an aggregated end-of-frame pulse.
// - Placed between the ANN/PostP engines and the result RAMs.
// PARAMETERS
// - NUM_CH   3     number of banks/channels
// - DATA_W   32    bank word width
// - ADDR_W   13    bank address width
// - DEPTH    4152  words per bank, <= 2**ADDR_W
// - END_ADDR 4151  ANN write address that marks the channel complete
// PORTS
// - iClk        in   1              clock
// - iReset_n    in   1              synchronous active-low reset
// - iRun_PostP  in   1              PostP owns all banks (level)
// - iAddr_ANN   in   NUM_CH*ADDR_W  per-channel ANN address, ch c at [c*ADDR_W+:ADDR_W]
// - iWrreq_ANN  in   NUM_CH         per-channel ANN write enable
// - iData_ANN   in   NUM_CH*DATA_W  per-channel ANN write data
// - iAddr_PostP in   NUM_CH*ADDR_W  per-channel PostP address
// - iWrreq_PostP in  NUM_CH         per-channel PostP write enable
// - iZr_PostP   in   NUM_CH*DATA_W  per-channel PostP write data
// - iRun_Set    in   1              enter Set mode (pulse)
// - iFinish_Set in   1              leave Set mode (pulse)
// - iAddr_Set   in   ADDR_W         Set address, broadcast to all banks
// - iWrreq_Set  in   1              Set write enable, broadcast
// - iData_Set   in   DATA_W         Set data, broadcast
// - iStart_Clear in  1              start Clear sweep (pulse)
// - iClear_Data in   DATA_W         fill word, sampled on accepted start
// - oData       out  NUM_CH*DATA_W  per-bank read data
// - oClear_Busy out  1              Clear sweep in progress
// - oClear_Done out  1              1-cycle pulse when the sweep finishes
// - oCh_Done    out  NUM_CH         sticky per-channel completion flags
// - oEnd        out  1              1-cycle pulse when all channels are done
// - oDrop       out  1              1-cycle pulse when a write is suppressed
// BEHAVIOUR
// - Reset: every output = 0; FSM = IDLE; set_mode = 0; Clear counter = 0.
//   RAM contents are not reset.
// - Owner priority per bank, per cycle: CLEAR > PostP > Set > ANN.
//   The address, data and wren of the winning owner drive the bank.
// - set_mode = iRun_Set ? 1 : iFinish_Set ? 0 : set_mode_q. The mux uses
//   this value in the same cycle; iRun_Set wins when both pulses are high.
// - FSM IDLE->CLEAR: on iStart_Clear in IDLE. Counter cnt=0; fill word is
//   latched from iClear_Data.
// - CLEAR: writes the fill word at cnt to all banks, cnt++ each cycle.
//   After the cnt==DEPTH-1 write, go to IDLE with oClear_Done=1 for 1 cycle.
//   A sweep takes exactly DEPTH cycles; oClear_Busy=1 throughout.
// - iStart_Clear during CLEAR is ignored; the sweep does not restart.
// - Any ANN/PostP/Set wrreq during CLEAR is discarded and pulses oDrop.
// - Any selected write with addr >= DEPTH is suppressed and pulses oDrop.
// - Completion: oCh_Done[c] sets when ANN is the selected owner of bank c,
//   iWrreq_ANN[c]=1 and addr==END_ADDR.
// - oEnd is registered: it pulses 1 cycle after all oCh_Done bits are 1,
//   and clears every oCh_Done bit in the same cycle.
// - Accepted iStart_Clear also clears oCh_Done. oEnd fires at most once
//   per frame.
// - Reads: oData is the RAM q of the selected address, 1-cycle latency.
//   A write cycle returns the old data (read-during-write = old).
// - Reset mid-Clear: the sweep aborts, the FSM goes to IDLE, and the RAM
//   is left partly cleared.
// CONFIGURATION
// - OM_BANK_RDREG_EN defined: each oData has an extra output register;
//   read latency = 2 cycles and the register resets to 0.
// - OM_BANK_RDREG_EN undefined: oData = RAM q directly, latency 1.
//   No other behaviour changes.
// STRUCTURE
// - Package om_pkg: owner enum {OWN_ANN, OWN_SET, OWN_POSTP, OWN_CLEAR};
//   FSM state enum {ST_IDLE, ST_CLEAR}; default DEPTH/END_ADDR constants.
// - Sub-module om_bank_ram #(DATA_W,ADDR_W,DEPTH): single-port sync RAM,
//   one instance per channel via generate.
// - Controller logic: owner mux, FSM and counter, done/end tracking.
// TESTING
// - Reset, then iStart_Clear with iClear_Data=32'hFFFF_FFFF. Expect
//   oClear_Busy=1 for 4152 cycles, a single oClear_Done pulse, and reads of
//   addr 0/4151 on every bank = FFFF_FFFF.
// - ANN writes ch0 addr 4151, then ch1, then ch2. Expect oCh_Done =
//   001 -> 011 -> 111, oEnd pulses 1 cycle after the ch2 write, and
//   oCh_Done returns to 000.
// - iRun_PostP=1 while ANN writes addr 4151 on ch2. Expect the PostP data
//   to be written and oCh_Done[2] to stay 0.
// - iRun_Set and iFinish_Set high in the same cycle. Expect set_mode=1,
//   and iWrreq_Set addr 5 data 32'h1234 to land in all three banks.
// - ANN wrreq during CLEAR, and ANN write to addr 4152 in IDLE. Each gives
//   an oDrop pulse and no RAM change.
// - iReset_n low at cnt=100 of a sweep. Expect oClear_Busy=0 the next
//   cycle and no oClear_Done pulse.

Source files
------------

// File: rtl/om_pkg.sv
// rtl/om_pkg.sv - shared owner/state enums and default geometry for the output-memory controller
package om_pkg;

    typedef enum logic [1:0] {
        OWN_ANN,
        OWN_SET,
        OWN_POSTP,
        OWN_CLEAR
    } owner_e;

    typedef enum logic {
        ST_IDLE,
        ST_CLEAR
    } state_e;

    localparam int OM_DEPTH    = 4152;
    localparam int OM_END_ADDR = 4151;

endpackage

// File: rtl/om_bank_ram.sv
// rtl/om_bank_ram.sv - single-port synchronous result bank, read-during-write returns old data
module om_bank_ram #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 13,
    parameter int DEPTH  = 4152
) (
    input  logic              iClk,
    input  logic              iReset_n,
    input  logic [ADDR_W-1:0] addr_i,
    input  logic              wren_i,
    input  logic [DATA_W-1:0] data_i,
    output logic [DATA_W-1:0] q_o
);

    logic [DATA_W-1:0] mem [0:DEPTH-1];
    logic [DATA_W-1:0] q_q;

    // Array write; contents are deliberately left unreset.
    always_ff @(posedge iClk) begin
        if (wren_i) begin
            mem[addr_i] <= data_i;
        end
    end

    // Registered read of the pre-write word; only the output latch resets.
    always_ff @(posedge iClk) begin
        if (!iReset_n) begin
            q_q <= '0;
        end else begin
            q_q <= mem[addr_i];
        end
    end

    assign q_o = q_q;

endmodule

// File: rtl/om_bank_ctrl.sv
// rtl/om_bank_ctrl.sv - owner mux, Clear sweep, completion tracking for NUM_CH result banks; option OM_BANK_RDREG_EN
module om_bank_ctrl
    import om_pkg::*;
#(
    parameter int NUM_CH   = 3,
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 13,
    parameter int DEPTH    = OM_DEPTH,
    parameter int END_ADDR = OM_END_ADDR
) (
    input  logic                     iClk,
    input  logic                     iReset_n,
    input  logic                     iRun_PostP,
    input  logic [NUM_CH*ADDR_W-1:0] iAddr_ANN,
    input  logic [NUM_CH-1:0]        iWrreq_ANN,
    input  logic [NUM_CH*DATA_W-1:0] iData_ANN,
    input  logic [NUM_CH*ADDR_W-1:0] iAddr_PostP,
    input  logic [NUM_CH-1:0]        iWrreq_PostP,
    input  logic [NUM_CH*DATA_W-1:0] iZr_PostP,
    input  logic                     iRun_Set,
    input  logic                     iFinish_Set,
    input  logic [ADDR_W-1:0]        iAddr_Set,
    input  logic                     iWrreq_Set,
    input  logic [DATA_W-1:0]        iData_Set,
    input  logic                     iStart_Clear,
    input  logic [DATA_W-1:0]        iClear_Data,
    output logic [NUM_CH*DATA_W-1:0] oData,
    output logic                     oClear_Busy,
    output logic                     oClear_Done,
    output logic [NUM_CH-1:0]        oCh_Done,
    output logic                     oEnd,
    output logic                     oDrop
);

    localparam logic [ADDR_W:0]   DEPTH_W = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W-1:0] LAST_A  = ADDR_W'(DEPTH - 1);
    localparam logic [ADDR_W-1:0] END_A   = ADDR_W'(END_ADDR);

    state_e              state_q, state_d;
    logic [ADDR_W-1:0]   cnt_q, cnt_d;
    logic [DATA_W-1:0]   fill_q, fill_d;
    logic                clear_done_q, clear_done_d;
    logic                set_mode_q, set_mode_d;
    logic [NUM_CH-1:0]   ch_done_q, ch_done_d;
    logic                end_q, end_d;
    logic                drop_q, drop_d;
    logic                start_accept;

    owner_e                         owner;
    logic [NUM_CH-1:0][ADDR_W-1:0]  sel_addr;
    logic [NUM_CH-1:0][DATA_W-1:0]  sel_data;
    logic [NUM_CH-1:0]              sel_req;
    logic [NUM_CH-1:0]              bank_we;
    logic [NUM_CH-1:0]              ann_hit;
    logic                           range_drop;
    logic                           clear_drop;
    logic [NUM_CH-1:0][DATA_W-1:0]  bank_q;

    assign set_mode_d   = iRun_Set ? 1'b1 : (iFinish_Set ? 1'b0 : set_mode_q);
    assign start_accept = (state_q == ST_IDLE) && iStart_Clear;

    // Bank ownership is mode-wide: Clear, then PostP, then Set, else ANN.
    always_comb begin
        owner = OWN_ANN;
        if (state_q == ST_CLEAR) begin
            owner = OWN_CLEAR;
        end else if (iRun_PostP) begin
            owner = OWN_POSTP;
        end else if (set_mode_d) begin
            owner = OWN_SET;
        end
    end

    // Per-bank address/data/write mux with range guard and completion detect.
    always_comb begin
        sel_addr   = '0;
        sel_data   = '0;
        sel_req    = '0;
        bank_we    = '0;
        ann_hit    = '0;
        range_drop = 1'b0;
        for (int c = 0; c < NUM_CH; c++) begin
            case (owner)
                OWN_CLEAR: begin
                    sel_addr[c] = cnt_q;
                    sel_data[c] = fill_q;
                    sel_req[c]  = 1'b1;
                end
                OWN_POSTP: begin
                    sel_addr[c] = iAddr_PostP[c*ADDR_W +: ADDR_W];
                    sel_data[c] = iZr_PostP[c*DATA_W +: DATA_W];
                    sel_req[c]  = iWrreq_PostP[c];
                end
                OWN_SET: begin
                    sel_addr[c] = iAddr_Set;
                    sel_data[c] = iData_Set;
                    sel_req[c]  = iWrreq_Set;
                end
                default: begin
                    sel_addr[c] = iAddr_ANN[c*ADDR_W +: ADDR_W];
                    sel_data[c] = iData_ANN[c*DATA_W +: DATA_W];
                    sel_req[c]  = iWrreq_ANN[c];
                end
            endcase
            if ({1'b0, sel_addr[c]} < DEPTH_W) begin
                bank_we[c] = sel_req[c];
            end else begin
                range_drop = range_drop | sel_req[c];
            end
            ann_hit[c] = (owner == OWN_ANN) && iWrreq_ANN[c] && (sel_addr[c] == END_A);
        end
    end

    // Engine writes arriving during a sweep are discarded rather than queued.
    assign clear_drop = (state_q == ST_CLEAR) &&
                        ((|iWrreq_ANN) || (|iWrreq_PostP) || iWrreq_Set);

    // Clear FSM next state: one word per cycle from 0 up to DEPTH-1.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        fill_d       = fill_q;
        clear_done_d = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (iStart_Clear) begin
                    state_d = ST_CLEAR;
                    cnt_d   = '0;
                    fill_d  = iClear_Data;
                end
            end
            ST_CLEAR: begin
                if (cnt_q == LAST_A) begin
                    state_d      = ST_IDLE;
                    cnt_d        = '0;
                    clear_done_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Completion flags: end-of-frame fires once all are set and wipes them.
    always_comb begin
        end_d  = &ch_done_q;
        drop_d = clear_drop | range_drop;
        if (start_accept) begin
            ch_done_d = '0;
        end else begin
            ch_done_d = (end_d ? '0 : ch_done_q) | ann_hit;
        end
    end

    // Controller state registers.
    always_ff @(posedge iClk) begin
        if (!iReset_n) begin
            state_q      <= ST_IDLE;
            cnt_q        <= '0;
            fill_q       <= '0;
            clear_done_q <= 1'b0;
            set_mode_q   <= 1'b0;
            ch_done_q    <= '0;
            end_q        <= 1'b0;
            drop_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            fill_q       <= fill_d;
            clear_done_q <= clear_done_d;
            set_mode_q   <= set_mode_d;
            ch_done_q    <= ch_done_d;
            end_q        <= end_d;
            drop_q       <= drop_d;
        end
    end

    genvar g;
    generate
        for (g = 0; g < NUM_CH; g++) begin : g_bank
            om_bank_ram #(
                .DATA_W (DATA_W),
                .ADDR_W (ADDR_W),
                .DEPTH  (DEPTH)
            ) u_ram (
                .iClk     (iClk),
                .iReset_n (iReset_n),
                .addr_i   (sel_addr[g]),
                .wren_i   (bank_we[g]),
                .data_i   (sel_data[g]),
                .q_o      (bank_q[g])
            );
`ifdef OM_BANK_RDREG_EN
            logic [DATA_W-1:0] rd_q;
            // Extra output stage for timing; adds one cycle of read latency.
            always_ff @(posedge iClk) begin
                if (!iReset_n) begin
                    rd_q <= '0;
                end else begin
                    rd_q <= bank_q[g];
                end
            end
            assign oData[g*DATA_W +: DATA_W] = rd_q;
`else
            assign oData[g*DATA_W +: DATA_W] = bank_q[g];
`endif
        end
    endgenerate

    assign oClear_Busy = (state_q == ST_CLEAR);
    assign oClear_Done = clear_done_q;
    assign oCh_Done    = ch_done_q;
    assign oEnd        = end_q;
    assign oDrop       = drop_q;

endmodule

// File: tb/tb_om_bank_ctrl.sv
// tb/tb_om_bank_ctrl.sv - scoreboard bench for om_bank_ctrl; honours OM_BANK_RDREG_EN read latency
module tb_om_bank_ctrl;

    localparam int NCH   = 3;
    localparam int DW    = 32;
    localparam int AW    = 13;
    localparam int DEPTH = 4152;
`ifdef OM_BANK_RDREG_EN
    localparam int RDLAT = 2;
`else
    localparam int RDLAT = 1;
`endif

    localparam int K_DATA = 0;
    localparam int K_CHD  = 1;
    localparam int K_BUSY = 2;
    localparam int K_DONE = 3;
    localparam int K_END  = 4;
    localparam int K_DROP = 5;

    logic                  clk = 1'b0;
    logic                  rst_n;
    logic                  run_postp;
    logic [NCH*AW-1:0]     addr_ann;
    logic [NCH-1:0]        wr_ann;
    logic [NCH*DW-1:0]     data_ann;
    logic [NCH*AW-1:0]     addr_pp;
    logic [NCH-1:0]        wr_pp;
    logic [NCH*DW-1:0]     zr_pp;
    logic                  run_set;
    logic                  fin_set;
    logic [AW-1:0]         addr_set;
    logic                  wr_set;
    logic [DW-1:0]         data_set;
    logic                  start_clr;
    logic [DW-1:0]         clr_data;
    logic [NCH*DW-1:0]     o_data;
    logic                  o_busy;
    logic                  o_done;
    logic [NCH-1:0]        o_chd;
    logic                  o_end;
    logic                  o_drop;

    always #5 clk = ~clk;

    om_bank_ctrl dut (
        .iClk         (clk),
        .iReset_n     (rst_n),
        .iRun_PostP   (run_postp),
        .iAddr_ANN    (addr_ann),
        .iWrreq_ANN   (wr_ann),
        .iData_ANN    (data_ann),
        .iAddr_PostP  (addr_pp),
        .iWrreq_PostP (wr_pp),
        .iZr_PostP    (zr_pp),
        .iRun_Set     (run_set),
        .iFinish_Set  (fin_set),
        .iAddr_Set    (addr_set),
        .iWrreq_Set   (wr_set),
        .iData_Set    (data_set),
        .iStart_Clear (start_clr),
        .iClear_Data  (clr_data),
        .oData        (o_data),
        .oClear_Busy  (o_busy),
        .oClear_Done  (o_done),
        .oCh_Done     (o_chd),
        .oEnd         (o_end),
        .oDrop        (o_drop)
    );

    typedef struct {
        int          cyc;
        int          kind;
        logic [95:0] val;
        string       name;
    } exp_t;

    exp_t        exp_q[$];
    int          cyc   = 0;
    int          n_vec = 0;
    int          n_bad = 0;
    int          k0;
    logic [95:0] act;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [NCH*AW-1:0] pa(int a0, int a1, int a2);
        return {AW'(a2), AW'(a1), AW'(a0)};
    endfunction

    function automatic logic [NCH*DW-1:0] pd(int unsigned d0, int unsigned d1, int unsigned d2);
        return {DW'(d2), DW'(d1), DW'(d0)};
    endfunction

    function automatic logic [95:0] actual(int kind);
        case (kind)
            K_DATA:  return o_data;
            K_CHD:   return {93'd0, o_chd};
            K_BUSY:  return {95'd0, o_busy};
            K_DONE:  return {95'd0, o_done};
            K_END:   return {95'd0, o_end};
            default: return {95'd0, o_drop};
        endcase
    endfunction

    function automatic bit pulse_expected(int kind);
        foreach (exp_q[i])
            if (exp_q[i].cyc == cyc && exp_q[i].kind == kind && exp_q[i].val[0]) return 1'b1;
        return 1'b0;
    endfunction

    task automatic expect_at(int off, int kind, logic [95:0] val, string name);
        exp_t e;
        e.cyc  = cyc + off;
        e.kind = kind;
        e.val  = val;
        e.name = name;
        exp_q.push_back(e);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic rd(int a0, int a1, int a2, logic [95:0] exp, string name);
        wr_ann   = '0;
        addr_ann = pa(a0, a1, a2);
        expect_at(RDLAT, K_DATA, exp, name);
        tick();
    endtask

    // Monitor: scoreboard pops on the falling edge, and flags any stray pulse.
    always @(negedge clk) begin
        if (o_end === 1'b1 && !pulse_expected(K_END)) begin
            n_vec++; n_bad++;
            $display("FAIL stray_oEnd cyc=%0d got 1 want 0", cyc);
        end
        if (o_drop === 1'b1 && !pulse_expected(K_DROP)) begin
            n_vec++; n_bad++;
            $display("FAIL stray_oDrop cyc=%0d got 1 want 0", cyc);
        end
        if (o_done === 1'b1 && !pulse_expected(K_DONE)) begin
            n_vec++; n_bad++;
            $display("FAIL stray_oClear_Done cyc=%0d got 1 want 0", cyc);
        end
        for (int i = exp_q.size() - 1; i >= 0; i--) begin
            if (exp_q[i].cyc == cyc) begin
                n_vec++;
                act = actual(exp_q[i].kind);
                if (act !== exp_q[i].val) begin
                    n_bad++;
                    $display("FAIL %s cyc=%0d got %h want %h", exp_q[i].name, cyc, act, exp_q[i].val);
                end
                exp_q.delete(i);
            end
        end
    end

    initial begin
        rst_n     = 1'b0;
        run_postp = 1'b0;
        addr_ann  = '0;
        wr_ann    = '0;
        data_ann  = '0;
        addr_pp   = '0;
        wr_pp     = '0;
        zr_pp     = '0;
        run_set   = 1'b0;
        fin_set   = 1'b0;
        addr_set  = '0;
        wr_set    = 1'b0;
        data_set  = '0;
        start_clr = 1'b0;
        clr_data  = '0;
        repeat (3) tick();

        expect_at(0, K_BUSY, 0, "rst_busy");
        expect_at(0, K_DONE, 0, "rst_done");
        expect_at(0, K_CHD,  0, "rst_chdone");
        expect_at(0, K_END,  0, "rst_end");
        expect_at(0, K_DROP, 0, "rst_drop");
        expect_at(0, K_DATA, 0, "rst_data");
        tick();
        rst_n = 1'b1;
        tick();

        // Full sweep with all-ones fill, an ANN write and a restart attempt mid-sweep.
        clr_data  = 32'hFFFF_FFFF;
        start_clr = 1'b1;
        k0 = cyc;
        expect_at(0,         K_BUSY, 0, "clr_busy_before");
        expect_at(1,         K_BUSY, 1, "clr_busy_first");
        expect_at(DEPTH,     K_BUSY, 1, "clr_busy_last");
        expect_at(DEPTH + 1, K_BUSY, 0, "clr_busy_after");
        expect_at(DEPTH + 1, K_DONE, 1, "clr_done_pulse");
        expect_at(11,        K_DROP, 1, "clr_ann_drop");
        tick();
        start_clr = 1'b0;
        clr_data  = '0;
        while (cyc < k0 + DEPTH + 2) begin
            wr_ann    = (cyc == k0 + 10) ? 3'b001 : 3'b000;
            addr_ann  = pa(7, 0, 0);
            data_ann  = pd(32'h55, 0, 0);
            start_clr = (cyc == k0 + 50);
            tick();
        end
        wr_ann    = '0;
        start_clr = 1'b0;

        rd(0, 0, 0,          {3{32'hFFFF_FFFF}}, "rd_addr0");
        rd(4151, 4151, 4151, {3{32'hFFFF_FFFF}}, "rd_addr4151");
        rd(7, 7, 7,          {3{32'hFFFF_FFFF}}, "rd_addr7_nodrop_write");

        // Channel completion and end-of-frame.
        wr_ann = 3'b001; addr_ann = pa(4151, 0, 0); data_ann = pd(32'hA0, 0, 0);
        expect_at(1, K_CHD, 3'b001, "chd_001");
        tick();
        wr_ann = 3'b010; addr_ann = pa(0, 4151, 0); data_ann = pd(0, 32'hA1, 0);
        expect_at(1, K_CHD, 3'b011, "chd_011");
        tick();
        wr_ann = 3'b100; addr_ann = pa(0, 0, 4151); data_ann = pd(0, 0, 32'hA2);
        expect_at(1, K_CHD, 3'b111, "chd_111");
        expect_at(2, K_END, 1,      "end_pulse");
        expect_at(2, K_CHD, 3'b000, "chd_cleared");
        expect_at(3, K_END, 0,      "end_single");
        tick();
        wr_ann = '0;
        repeat (3) tick();

        // PostP overrides an ANN end-address write on ch2.
        run_postp = 1'b1;
        addr_pp   = pa(0, 0, 4151); wr_pp = 3'b100; zr_pp = pd(0, 0, 32'hB2);
        addr_ann  = pa(0, 0, 4151); wr_ann = 3'b100; data_ann = pd(0, 0, 32'hC2);
        expect_at(1, K_CHD, 3'b000, "postp_no_chdone");
        expect_at(2, K_CHD, 3'b000, "postp_no_chdone2");
        tick();
        run_postp = 1'b0; wr_pp = '0; wr_ann = '0;
        rd(4151, 4151, 4151, {32'hB2, 32'hA1, 32'hA0}, "rd_postp_won");

        // Simultaneous Set enter/leave: enter wins, broadcast write lands.
        run_set = 1'b1; fin_set = 1'b1; wr_set = 1'b1; addr_set = 5; data_set = 32'h1234;
        tick();
        run_set = 1'b0; fin_set = 1'b0; wr_set = 1'b0;
        addr_ann = pa(0, 0, 0);
        expect_at(RDLAT, K_DATA, {3{32'h0000_1234}}, "rd_set_mode_held");
        tick();
        fin_set  = 1'b1;
        tick();
        fin_set  = 1'b0;
        addr_set = 0;
        rd(5, 5, 5, {3{32'h0000_1234}}, "rd_set_landed");
        rd(0, 0, 0, {3{32'hFFFF_FFFF}}, "rd_set_exited");

        // Out-of-range ANN write.
        wr_ann = 3'b010; addr_ann = pa(0, 4152, 0); data_ann = pd(0, 32'hDEAD, 0);
        expect_at(1, K_DROP, 1,      "oor_drop");
        expect_at(1, K_CHD,  3'b000, "oor_no_chdone");
        tick();
        wr_ann = '0;
        rd(4151, 4151, 4151, {32'hB2, 32'hA1, 32'hA0}, "rd_after_oor");

        // Reset in the middle of a sweep.
        clr_data  = 32'h0000_00C3;
        start_clr = 1'b1;
        k0 = cyc;
        tick();
        start_clr = 1'b0;
        while (cyc < k0 + 101) tick();
        expect_at(0, K_BUSY, 1, "midrst_busy_before");
        expect_at(1, K_BUSY, 0, "midrst_busy_after");
        expect_at(1, K_DONE, 0, "midrst_no_done");
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        repeat (4) tick();
        rd(50, 50, 50,    {3{32'h0000_00C3}}, "rd_partial_cleared");
        rd(200, 200, 200, {3{32'hFFFF_FFFF}}, "rd_partial_untouched");
        repeat (20) tick();

        foreach (exp_q[i]) begin
            n_vec++; n_bad++;
            $display("FAIL %s never_checked due_cyc=%0d", exp_q[i].name, exp_q[i].cyc);
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
